// File: rtl/phy_ts_os_receiver.sv
// -----------------------------------------------------------------------------
// phy_ts_os_receiver
//
// Receive-side TS1/TS2 ordered-set parser for one PHY lane. Consumes the
// 8b/10b-decoded symbol stream, frames 16-symbol training sets that begin
// with COM, captures the link/lane/N_FTS/rate/training-control fields, and
// counts consecutive identical sets so LTSSM Polling/Config can see lock.
//
// Parameters
//   MATCH_COUNT  consecutive identical sets needed for ts1_locked/ts2_locked
//   CNT_W        width of ts_match_cnt; the count saturates at 2**CNT_W-1
//
// Ports
//   clk            lane symbol clock
//   rst_n          asynchronous active-low reset
//   rx_valid       symbol valid this cycle
//   rx_data        decoded symbol
//   rx_datak       1 = K symbol
//   os_valid       1-cycle pulse: a well-formed TS was captured
//   os_is_ts2      type of the captured set (0 = TS1, 1 = TS2)
//   os_link_num    symbol 1 (0xF7 = PAD)
//   os_lane_num    symbol 2 (0xF7 = PAD)
//   os_n_fts       symbol 3
//   os_rate_id     symbol 4
//   os_train_ctrl  symbol 5
//   os_err         1-cycle pulse: malformed or aborted set
//   ts_match_cnt   consecutive identical TS count
//   ts1_locked     count >= MATCH_COUNT and last set was TS1
//   ts2_locked     count >= MATCH_COUNT and last set was TS2
//   skp_seen       1-cycle pulse: a SKP ordered set ended (filter build only)
//
// Build option
//   PHY_TS_SKP_FILTER_EN  when defined, COM followed by SKP is recognised as a
//                         SKP ordered set and absorbed without error; the
//                         skp_seen port exists only in that build.
// -----------------------------------------------------------------------------
module phy_ts_os_receiver #(
    parameter int MATCH_COUNT = 8,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    input  logic             rx_datak,
    output logic             os_valid,
    output logic             os_is_ts2,
    output logic [7:0]       os_link_num,
    output logic [7:0]       os_lane_num,
    output logic [7:0]       os_n_fts,
    output logic [7:0]       os_rate_id,
    output logic [7:0]       os_train_ctrl,
    output logic             os_err,
    output logic [CNT_W-1:0] ts_match_cnt,
    output logic             ts1_locked,
    output logic             ts2_locked
`ifdef PHY_TS_SKP_FILTER_EN
    ,
    output logic             skp_seen
`endif
);

    localparam logic [7:0] SYM_COM = 8'hBC;
    localparam logic [7:0] SYM_PAD = 8'hF7;
    localparam logic [7:0] SYM_SKP = 8'h1C;
    localparam logic [7:0] ID_TS1  = 8'h4A;
    localparam logic [7:0] ID_TS2  = 8'h45;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_THR = CNT_W'(MATCH_COUNT);

    // HUNT waits for COM, FIELDS holds symbols 1..5, IDENT holds 6..15,
    // SKP absorbs the body of a SKP ordered set (filter build only).
    typedef enum logic [1:0] {
        S_HUNT   = 2'd0,
        S_FIELDS = 2'd1,
        S_IDENT  = 2'd2,
        S_SKP    = 2'd3
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] idx;        // position of the symbol expected next, 1..15
    logic [3:0] idx_next;

    // Symbol decode
    logic is_com;
    logic is_pad;
    logic is_skp;
    logic sym_ok;           // symbol is legal at the current position
    logic skp_enter;        // COM+SKP recognised as a SKP ordered set

    // Field capture for the set in flight
    logic [7:0] link_q;
    logic [7:0] lane_q;
    logic [7:0] nfts_q;
    logic [7:0] rate_q;
    logic [7:0] ctrl_q;
    logic [7:0] id_q;

    // Per-cycle events and next values of the registered outputs
    logic             err_evt;
    logic             done_evt;
    logic             new_ts2;
    logic             same_set;
    logic             type_next;
    logic [CNT_W-1:0] cnt_next;
    logic             lock1_next;
    logic             lock2_next;

    assign is_com = rx_datak && (rx_data == SYM_COM);
    assign is_pad = rx_datak && (rx_data == SYM_PAD);
    assign is_skp = rx_datak && (rx_data == SYM_SKP);

`ifdef PHY_TS_SKP_FILTER_EN
    logic skp_evt;
    assign skp_enter = (state == S_FIELDS) && (idx == 4'd1) && rx_valid && is_skp;
    // Any valid non-SKP symbol closes the SKP set; it is then judged as in HUNT.
    assign skp_evt   = (state == S_SKP) && rx_valid && !is_skp;
`else
    assign skp_enter = 1'b0;
`endif

    // Positional legality. COM and SKP are K symbols other than PAD, so they
    // are never legal inside a set and fall out as violations here.
    always_comb begin
        sym_ok = 1'b0;
        if (state == S_FIELDS) begin
            if (idx <= 4'd2) begin
                sym_ok = !rx_datak || is_pad;
            end else begin
                sym_ok = !rx_datak;
            end
        end else if (state == S_IDENT) begin
            if (idx == 4'd6) begin
                sym_ok = !rx_datak && ((rx_data == ID_TS1) || (rx_data == ID_TS2));
            end else begin
                sym_ok = !rx_datak && (rx_data == id_q);
            end
        end
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_HUNT;
            idx   <= 4'd0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------------
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        case (state)
            S_HUNT: begin
                if (rx_valid && is_com) begin
                    state_next = S_FIELDS;
                    idx_next   = 4'd1;
                end
            end
            S_FIELDS, S_IDENT: begin
                if (!rx_valid) begin
                    state_next = S_HUNT;
                end else if (is_com) begin
                    // Violation, but this COM already opens the next set.
                    state_next = S_FIELDS;
                    idx_next   = 4'd1;
                end else if (skp_enter) begin
                    state_next = S_SKP;
                end else if (!sym_ok) begin
                    state_next = S_HUNT;
                end else if (idx == 4'd15) begin
                    state_next = S_HUNT;
                end else begin
                    idx_next = idx + 4'd1;
                    if (idx == 4'd5) begin
                        state_next = S_IDENT;
                    end
                end
            end
            S_SKP: begin
                if (rx_valid && !is_skp) begin
                    if (is_com) begin
                        state_next = S_FIELDS;
                        idx_next   = 4'd1;
                    end else begin
                        state_next = S_HUNT;
                    end
                end
            end
            default: begin
                state_next = S_HUNT;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs (events and next values of the registered outputs)
    // -------------------------------------------------------------------------
    always_comb begin
        err_evt  = 1'b0;
        done_evt = 1'b0;
        if ((state == S_FIELDS) || (state == S_IDENT)) begin
            if (!rx_valid) begin
                err_evt = 1'b1;
            end else if (!sym_ok && !skp_enter) begin
                err_evt = 1'b1;
            end else if ((state == S_IDENT) && (idx == 4'd15)) begin
                done_evt = 1'b1;
            end
        end

        // Compare against the previous completed set, which is exactly what
        // the os_* outputs hold (they never move on an aborted set).
        new_ts2  = (id_q == ID_TS2);
        same_set = (ts_match_cnt != '0)
                && (new_ts2 == os_is_ts2)
                && (link_q  == os_link_num)
                && (lane_q  == os_lane_num)
                && (nfts_q  == os_n_fts)
                && (rate_q  == os_rate_id)
                && (ctrl_q  == os_train_ctrl);

        cnt_next = ts_match_cnt;
        if (done_evt) begin
            if (!same_set) begin
                cnt_next = CNT_ONE;
            end else if (ts_match_cnt != CNT_MAX) begin
                cnt_next = ts_match_cnt + CNT_ONE;
            end
        end else if (err_evt) begin
            cnt_next = '0;
        end

        type_next  = done_evt ? new_ts2 : os_is_ts2;
        lock1_next = (cnt_next != '0) && (cnt_next >= CNT_THR) && !type_next;
        lock2_next = (cnt_next != '0) && (cnt_next >= CNT_THR) &&  type_next;
    end

    // -------------------------------------------------------------------------
    // Field capture
    // -------------------------------------------------------------------------
    // NOTE: capture registers are deliberately not reset: each is written at
    // its position before anything reads it, and the visible os_* copies are.
    always_ff @(posedge clk) begin
        if (rx_valid && sym_ok) begin
            if (state == S_FIELDS) begin
                case (idx)
                    4'd1:    link_q <= rx_data;
                    4'd2:    lane_q <= rx_data;
                    4'd3:    nfts_q <= rx_data;
                    4'd4:    rate_q <= rx_data;
                    4'd5:    ctrl_q <= rx_data;
                    default: ;
                endcase
            end else if ((state == S_IDENT) && (idx == 4'd6)) begin
                id_q <= rx_data;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            os_valid      <= 1'b0;
            os_err        <= 1'b0;
            os_is_ts2     <= 1'b0;
            os_link_num   <= 8'h00;
            os_lane_num   <= 8'h00;
            os_n_fts      <= 8'h00;
            os_rate_id    <= 8'h00;
            os_train_ctrl <= 8'h00;
            ts_match_cnt  <= '0;
            ts1_locked    <= 1'b0;
            ts2_locked    <= 1'b0;
        end else begin
            os_valid     <= done_evt;
            os_err       <= err_evt;
            ts_match_cnt <= cnt_next;
            ts1_locked   <= lock1_next;
            ts2_locked   <= lock2_next;
            if (done_evt) begin
                os_is_ts2     <= new_ts2;
                os_link_num   <= link_q;
                os_lane_num   <= lane_q;
                os_n_fts      <= nfts_q;
                os_rate_id    <= rate_q;
                os_train_ctrl <= ctrl_q;
            end
        end
    end

`ifdef PHY_TS_SKP_FILTER_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skp_seen <= 1'b0;
        end else begin
            skp_seen <= skp_evt;
        end
    end
`endif

endmodule
